// File: rtl/pattern_gen_if.sv
// pattern_gen_if: video timing/fill inputs and delayed sync/RGB outputs of
// the test-pattern generator. The timing source drives through master; the
// generator consumes through slave.
interface pattern_gen_if;
  logic       vs_in;
  logic       hs_in;
  logic       de_in;
  logic [7:0] pattern_set;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       vs_out;
  logic       hs_out;
  logic       de_out;
  logic [7:0] r_out;
  logic [7:0] g_out;
  logic [7:0] b_out;

  modport master (
    output vs_in, hs_in, de_in, pattern_set, red, green, blue,
    input  vs_out, hs_out, de_out, r_out, g_out, b_out
  );

  modport slave (
    input  vs_in, hs_in, de_in, pattern_set, red, green, blue,
    output vs_out, hs_out, de_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/pattern_gen.sv
// pattern_gen: video test-pattern generator, 2-stage pipeline.
// Pattern select and fill colour are latched on the vs_in rising edge so the
// image never changes mid-frame. Syncs/DE and RGB leave 2 cycles after input.
// Optional macro PATTERN_GEN_GRID_EN: patterns 5-7 draw a 64-pixel grid over
// the fill colour; without it those selects output black.
module pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int BAR_W    = 160
) (
  input  logic          clk,
  input  logic          rst_n,
  pattern_gen_if.slave  bus
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_WHITE   = 24'hFFFFFF;
  localparam rgb_t C_YELLOW  = 24'hFFFF00;
  localparam rgb_t C_CYAN    = 24'h00FFFF;
  localparam rgb_t C_GREEN   = 24'h00FF00;
  localparam rgb_t C_MAGENTA = 24'hFF00FF;
  localparam rgb_t C_RED     = 24'hFF0000;
  localparam rgb_t C_BLUE    = 24'h0000FF;
  localparam rgb_t C_BLACK   = 24'h000000;

  // stage-0 state: edge detectors, frame latch, pixel counters
  logic        r_vs_d;
  logic        r_de_d;
  logic [2:0]  r_pat_q;
  rgb_t        r_fill_q;
  logic [11:0] r_x_cnt;
  logic [11:0] r_y_cnt;
  logic [11:0] r_bar_pix;
  logic [2:0]  r_bar_idx;

  // pipeline
  logic [STAGES:1] r_vld_pipe;
  logic [STAGES:1] r_hs_pipe;
  logic [STAGES:1] r_vs_pipe;
  logic [11:0]     r_s1_x;
  logic [11:0]     r_s1_y;
  logic [2:0]      r_s1_bar;
  rgb_t            r_pix;
  rgb_t            w_pix;

  logic w_vs_rise;
  logic w_de_fall;
  logic w_unused_pat;

  assign w_vs_rise    = bus.vs_in & ~r_vs_d;
  assign w_de_fall    = ~bus.de_in & r_de_d;
  assign w_unused_pat = ^bus.pattern_set[7:3];

  // registered copies of vs_in/de_in for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
    end else begin
      r_vs_d <= bus.vs_in;
      r_de_d <= bus.de_in;
    end
  end

  // pattern and fill colour held for a whole frame; power-up pattern is the ramp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat_q  <= 3'd4;
      r_fill_q <= '0;
    end else if (w_vs_rise) begin
      r_pat_q  <= bus.pattern_set[2:0];
      r_fill_q <= {bus.red, bus.green, bus.blue};
    end
  end

  // horizontal pixel counter: counts DE cycles, cleared in blanking, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_x_cnt <= '0;
    else if (!bus.de_in)
      r_x_cnt <= '0;
    else if (r_x_cnt != 12'hFFF)
      r_x_cnt <= r_x_cnt + 12'd1;
  end

  // line counter: steps at each end of active line, cleared at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_y_cnt <= '0;
    else if (w_vs_rise)
      r_y_cnt <= '0;
    else if (w_de_fall && (r_y_cnt != 12'hFFF))
      r_y_cnt <= r_y_cnt + 12'd1;
  end

  // colour-bar index tracked by a pixel-within-bar counter instead of a divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else if (!bus.de_in) begin
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_pix == 12'(BAR_W - 1)) begin
      r_bar_pix <= '0;
      if (r_bar_idx != 3'd7)
        r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_pix <= r_bar_pix + 12'd1;
    end
  end

  // sync and DE shift registers, one bit per pipeline stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_hs_pipe  <= '0;
      r_vs_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.de_in};
      r_hs_pipe  <= {r_hs_pipe[STAGES-1:1],  bus.hs_in};
      r_vs_pipe  <= {r_vs_pipe[STAGES-1:1],  bus.vs_in};
    end
  end

  // stage 1: capture the coordinates belonging to the incoming pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s1_bar <= '0;
    end else begin
      r_s1_x   <= r_x_cnt;
      r_s1_y   <= r_y_cnt;
      r_s1_bar <= r_bar_idx;
    end
  end

  // pattern decode from stage-1 coordinates and the frame-latched selection
  always_comb begin
    w_pix = C_BLACK;
    case (r_pat_q)
      3'd0: w_pix = r_fill_q;
      3'd1: begin
        if ((r_s1_x == '0) || (r_s1_x == 12'(H_ACTIVE - 1)) ||
            (r_s1_y == '0) || (r_s1_y == 12'(V_ACTIVE - 1)))
          w_pix = C_WHITE;
        else
          w_pix = r_fill_q;
      end
      3'd2: begin
        case (r_s1_bar)
          3'd0: w_pix = C_WHITE;
          3'd1: w_pix = C_YELLOW;
          3'd2: w_pix = C_CYAN;
          3'd3: w_pix = C_GREEN;
          3'd4: w_pix = C_MAGENTA;
          3'd5: w_pix = C_RED;
          3'd6: w_pix = C_BLUE;
          default: w_pix = C_BLACK;
        endcase
      end
      3'd3: w_pix = (r_s1_x[5] ^ r_s1_y[5]) ? C_WHITE : C_BLACK;
      3'd4: w_pix = {r_s1_x[7:0], r_s1_x[7:0], r_s1_x[7:0]};
`ifdef PATTERN_GEN_GRID_EN
      default: begin
        if ((r_s1_x[5:0] == 6'd0) || (r_s1_y[5:0] == 6'd0) ||
            (r_s1_x == 12'(H_ACTIVE - 1)) || (r_s1_y == 12'(V_ACTIVE - 1)))
          w_pix = C_WHITE;
        else
          w_pix = r_fill_q;
      end
`else
      default: w_pix = C_BLACK;
`endif
    endcase
  end

  // stage 2: register the pixel, blanked to black outside active video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pix <= '0;
    else
      r_pix <= r_vld_pipe[1] ? w_pix : C_BLACK;
  end

  assign bus.vs_out = r_vs_pipe[STAGES];
  assign bus.hs_out = r_hs_pipe[STAGES];
  assign bus.de_out = r_vld_pipe[STAGES];
  assign bus.r_out  = r_pix.r;
  assign bus.g_out  = r_pix.g;
  assign bus.b_out  = r_pix.b;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: drives frames into pattern_gen, keeps a scoreboard of
// expected pixels, and spot-checks captured pixels per scenario.
module tb_pattern_gen;
  localparam int H  = 1280;
  localparam int V  = 4;
  localparam int BW = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_gen_if bus ();

  pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          tb_pat;
  logic [23:0] tb_fill;
  int          tb_y;
  logic [23:0] cap [0:63][0:1279];
  logic [23:0] bars [0:7];

  function automatic logic [23:0] exp_pix(input int pat, input logic [23:0] fill,
                                          input int x, input int y);
    int b;
    case (pat)
      0: return fill;
      1: return (x == 0 || x == H-1 || y == 0 || y == V-1) ? 24'hFFFFFF : fill;
      2: begin
        b = x / BW;
        if (b > 7) b = 7;
        return bars[b];
      end
      3: return (((x ^ y) >> 5) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      4: return {3{8'(x & 255)}};
      default: begin
`ifdef PATTERN_GEN_GRID_EN
        return ((x % 64) == 0 || (y % 64) == 0 || x == H-1 || y == V-1) ? 24'hFFFFFF : fill;
`else
        return 24'h000000;
`endif
      end
    endcase
  endfunction

  task automatic cyc(input logic vs, input logic hs, input logic de);
    @(posedge clk); #1;
    bus.vs_in = vs;
    bus.hs_in = hs;
    bus.de_in = de;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_cap();
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 1280; xx++)
        cap[yy][xx] = 'x;
  endtask

  // pattern_set and colour change on the very cycle vs_in rises
  task automatic drive_vs(input logic [7:0] ps, input logic [23:0] col);
    idle(2);
    clear_cap();
    @(posedge clk); #1;
    bus.pattern_set = ps;
    {bus.red, bus.green, bus.blue} = col;
    bus.vs_in = 1'b1; bus.hs_in = 1'b0; bus.de_in = 1'b0;
    tb_pat = int'(ps[2:0]); tb_fill = col; tb_y = 0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    idle(4);
  endtask

  task automatic drive_line(input int npix);
    for (int i = 0; i < 16; i++) cyc(1'b0, (i >= 2 && i < 6), 1'b0);
    for (int x = 0; x < npix; x++) begin
      cyc(1'b0, 1'b0, 1'b1);
      sb.push_back('{x, tb_y, exp_pix(tb_pat, tb_fill, x, tb_y)});
    end
    cyc(1'b0, 1'b0, 1'b0);
    tb_y++;
  endtask

  // scoreboard monitor: syncs vs 2-cycle-old inputs, pixels vs expected queue
  initial begin
    logic [2:0]  h1, h2;
    logic [23:0] act;
    exp_t        e;
    h1 = '0; h2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        h1 = '0; h2 = '0;
      end else begin
        n_tests++;
        if ({bus.vs_out, bus.hs_out, bus.de_out} !== h2) begin
          n_fail++;
          $display("FAIL sync_lag: got %b want %b at %0t", {bus.vs_out, bus.hs_out, bus.de_out}, h2, $time);
        end
        act = {bus.r_out, bus.g_out, bus.b_out};
        if (bus.de_out === 1'b1) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL pix_extra: got %h want no pixel at %0t", act, $time);
          end else begin
            e = sb.pop_front();
            if (act !== e.rgb) begin
              n_fail++;
              $display("FAIL pix(%0d,%0d): got %h want %h", e.x, e.y, act, e.rgb);
            end
            if (e.y < 64 && e.x < 1280) cap[e.y][e.x] = act;
          end
        end else begin
          n_tests++;
          if (act !== 24'h0) begin
            n_fail++;
            $display("FAIL blank_rgb: got %h want 000000 at %0t", act, $time);
          end
        end
        h2 = h1;
        h1 = {bus.vs_in, bus.hs_in, bus.de_in};
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.vs_out, bus.hs_out, bus.de_out, bus.r_out, bus.g_out, bus.b_out} !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", {bus.vs_out, bus.hs_out, bus.de_out, bus.r_out, bus.g_out, bus.b_out});
    end
    n_tests++;
    if (dut.r_pat_q !== 3'd4) begin
      n_fail++; $display("FAIL reset_pat: got %0d want 4", dut.r_pat_q);
    end
    n_tests++;
    if (dut.r_fill_q !== 24'h0) begin
      n_fail++; $display("FAIL reset_fill: got %h want 000000", dut.r_fill_q);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_pat = 4; tb_fill = 24'h0; tb_y = 0;
    idle(4);
  endtask

  task automatic test_solid();
    drive_vs(8'h00, 24'h00FF00);
    drive_line(H);
    drive_line(H);
    idle(4);
    n_tests++;
    if (cap[0][0] !== 24'h00FF00) begin n_fail++; $display("FAIL solid_first: got %h want 00ff00", cap[0][0]); end
    n_tests++;
    if (cap[1][1279] !== 24'h00FF00) begin n_fail++; $display("FAIL solid_last: got %h want 00ff00", cap[1][1279]); end
  endtask

  task automatic test_border();
    drive_vs(8'h01, 24'h102030);
    for (int l = 0; l < V; l++) drive_line(H);
    idle(4);
    n_tests++;
    if (cap[0][5] !== 24'hFFFFFF) begin n_fail++; $display("FAIL border_top: got %h want ffffff", cap[0][5]); end
    n_tests++;
    if (cap[1][0] !== 24'hFFFFFF) begin n_fail++; $display("FAIL border_left: got %h want ffffff", cap[1][0]); end
    n_tests++;
    if (cap[2][1279] !== 24'hFFFFFF) begin n_fail++; $display("FAIL border_right: got %h want ffffff", cap[2][1279]); end
    n_tests++;
    if (cap[3][7] !== 24'hFFFFFF) begin n_fail++; $display("FAIL border_bottom: got %h want ffffff", cap[3][7]); end
    n_tests++;
    if (cap[1][5] !== 24'h102030) begin n_fail++; $display("FAIL border_inner: got %h want 102030", cap[1][5]); end
  endtask

  task automatic test_bars();
    drive_vs(8'h02, 24'h123456);
    drive_line(H);
    idle(4);
    n_tests++;
    if (cap[0][159] !== 24'hFFFFFF) begin n_fail++; $display("FAIL bar_159: got %h want ffffff", cap[0][159]); end
    n_tests++;
    if (cap[0][160] !== 24'hFFFF00) begin n_fail++; $display("FAIL bar_160: got %h want ffff00", cap[0][160]); end
    n_tests++;
    if (cap[0][480] !== 24'h00FF00) begin n_fail++; $display("FAIL bar_480: got %h want 00ff00", cap[0][480]); end
    n_tests++;
    if (cap[0][1120] !== 24'h000000) begin n_fail++; $display("FAIL bar_1120: got %h want 000000", cap[0][1120]); end
    n_tests++;
    if (cap[0][1279] !== 24'h000000) begin n_fail++; $display("FAIL bar_1279: got %h want 000000", cap[0][1279]); end
  endtask

  task automatic test_checker();
    drive_vs(8'h03, 24'h123456);
    for (int l = 0; l < 33; l++) drive_line(64);
    idle(4);
    n_tests++;
    if (cap[0][31] !== 24'h000000) begin n_fail++; $display("FAIL chk_31_0: got %h want 000000", cap[0][31]); end
    n_tests++;
    if (cap[0][32] !== 24'hFFFFFF) begin n_fail++; $display("FAIL chk_32_0: got %h want ffffff", cap[0][32]); end
    n_tests++;
    if (cap[32][32] !== 24'h000000) begin n_fail++; $display("FAIL chk_32_32: got %h want 000000", cap[32][32]); end
  endtask

  task automatic test_ramp();
    drive_vs(8'hF4, 24'h123456);
    drive_line(300);
    idle(4);
    n_tests++;
    if (cap[0][5] !== 24'h050505) begin n_fail++; $display("FAIL ramp_5: got %h want 050505", cap[0][5]); end
    n_tests++;
    if (cap[0][255] !== 24'hFFFFFF) begin n_fail++; $display("FAIL ramp_255: got %h want ffffff", cap[0][255]); end
    n_tests++;
    if (cap[0][256] !== 24'h000000) begin n_fail++; $display("FAIL ramp_256: got %h want 000000", cap[0][256]); end
    n_tests++;
    if ({bus.de_out, bus.r_out, bus.g_out, bus.b_out} !== 25'h0) begin
      n_fail++; $display("FAIL ramp_blank: got %h want 0", {bus.de_out, bus.r_out, bus.g_out, bus.b_out});
    end
  endtask

  task automatic test_midframe();
    drive_vs(8'h00, 24'h0000FF);
    drive_line(H);
    bus.pattern_set = 8'h02;
    {bus.red, bus.green, bus.blue} = 24'hFF0000;
    drive_line(H);
    idle(4);
    n_tests++;
    if (cap[1][0] !== 24'h0000FF) begin n_fail++; $display("FAIL mid_hold0: got %h want 0000ff", cap[1][0]); end
    n_tests++;
    if (cap[1][1279] !== 24'h0000FF) begin n_fail++; $display("FAIL mid_hold1279: got %h want 0000ff", cap[1][1279]); end
    drive_vs(8'h02, 24'hFF0000);
    drive_line(H);
    idle(4);
    n_tests++;
    if (cap[0][0] !== 24'hFFFFFF) begin n_fail++; $display("FAIL mid_bars0: got %h want ffffff", cap[0][0]); end
    n_tests++;
    if (cap[0][160] !== 24'hFFFF00) begin n_fail++; $display("FAIL mid_bars160: got %h want ffff00", cap[0][160]); end
  endtask

  task automatic test_grid();
    logic [23:0] w_white, w_fill;
`ifdef PATTERN_GEN_GRID_EN
    w_white = 24'hFFFFFF; w_fill = 24'h123456;
`else
    w_white = 24'h000000; w_fill = 24'h000000;
`endif
    drive_vs(8'h05, 24'h123456);
    for (int l = 0; l < 11; l++) drive_line(80);
    idle(4);
    n_tests++;
    if (cap[0][0] !== w_white) begin n_fail++; $display("FAIL grid_0_0: got %h want %h", cap[0][0], w_white); end
    n_tests++;
    if (cap[10][64] !== w_white) begin n_fail++; $display("FAIL grid_64_10: got %h want %h", cap[10][64], w_white); end
    n_tests++;
    if (cap[1][1] !== w_fill) begin n_fail++; $display("FAIL grid_1_1: got %h want %h", cap[1][1], w_fill); end
  endtask

  task automatic test_reset_midline();
    drive_vs(8'h03, 24'hAABBCC);
    for (int i = 0; i < 16; i++) cyc(1'b0, (i >= 2 && i < 6), 1'b0);
    for (int x = 0; x < 100; x++) begin
      cyc(1'b0, 1'b0, 1'b1);
      sb.push_back('{x, tb_y, exp_pix(tb_pat, tb_fill, x, tb_y)});
    end
    #2;
    n_tests++;
    if (bus.de_out !== 1'b1) begin n_fail++; $display("FAIL rst_pre_de: got %b want 1", bus.de_out); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.vs_out, bus.hs_out, bus.de_out, bus.r_out, bus.g_out, bus.b_out} !== 27'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outs: got %h want 0", {bus.vs_out, bus.hs_out, bus.de_out, bus.r_out, bus.g_out, bus.b_out});
    end
    n_tests++;
    if (dut.r_pat_q !== 3'd4) begin n_fail++; $display("FAIL rst_mid_pat: got %0d want 4", dut.r_pat_q); end
    for (int x = 0; x < 50; x++) cyc(1'b0, 1'b0, 1'b1);
    idle(3);
    sb.delete();
    rst_n = 1'b1;
    tb_pat = 4; tb_fill = 24'h0; tb_y = 0;
    clear_cap();
    drive_line(300);
    idle(4);
    n_tests++;
    if (cap[0][5] !== 24'h050505) begin n_fail++; $display("FAIL rst_restart5: got %h want 050505", cap[0][5]); end
    n_tests++;
    if (cap[0][200] !== 24'hC8C8C8) begin n_fail++; $display("FAIL rst_restart200: got %h want c8c8c8", cap[0][200]); end
  endtask

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    bus.vs_in = 1'b0; bus.hs_in = 1'b0; bus.de_in = 1'b0;
    bus.pattern_set = 8'h00; bus.red = 8'h00; bus.green = 8'h00; bus.blue = 8'h00;
    tb_pat = 4; tb_fill = 24'h0; tb_y = 0;
    clear_cap();
    test_reset();
    test_solid();
    test_border();
    test_bars();
    test_checker();
    test_ramp();
    test_midframe();
    test_grid();
    test_reset_midline();
    idle(4);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Video test-pattern generator directly downstream of the button controller. Takes the controller's `pattern_set` and fill colour (`red`/`green`/`blue`) plus raw sync/DE from the video timing generator, and produces RGB pixels with matching delayed syncs for the display output stage. Pattern and colour are sampled once per frame, so the image never changes mid-frame.

## Interface
- `H_ACTIVE`, 1280: active pixels per line (≤ 4095).
- `V_ACTIVE`, 720: active lines per frame (≤ 4095).
- `BAR_W`, 160: colour-bar width in pixels (H_ACTIVE/8).
- `clk  in  1`: pixel clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `vs_in  in  1`: vertical sync, active high.
- `hs_in  in  1`: horizontal sync, active high.
- `de_in  in  1`: data enable, high during active pixels.
- `pattern_set  in  8`: pattern select; bits [2:0] used, [7:3] ignored.
- `red`, `green`, `blue`  `in  8` each: fill colour.
- `vs_out`, `hs_out`, `de_out`  `out  1` each: syncs delayed 2 cycles.
- `r_out`, `g_out`, `b_out`  `out  8` each: pixel colour, aligned with `de_out`.

## Operation
- Frame latch: on the rising edge of `vs_in` (`vs_in`=1, registered copy=0), `pat_q` ← `pattern_set[2:0]` and `fill_q` ← {red, green, blue}. Both hold for the whole frame.
- `x_cnt` (12 b):
  - Increments on every cycle with `de_in`=1.
  - Clears on any cycle with `de_in`=0.
  - Saturates at 4095.
- `y_cnt` (12 b):
  - Increments on each falling edge of `de_in`.
  - Clears on the rising edge of `vs_in`.
  - Saturates at 4095.
- `bar_idx` (3 b) and `bar_pix` counter:
  - Both clear when `de_in`=0.
  - `bar_idx` increments when `bar_pix` reaches BAR_W-1; `bar_pix` then wraps to 0.
  - `bar_idx` saturates at 7. No divider is used.
- Pattern decode on `pat_q` (x, y are the pixel's counter values):
  - 0: solid `fill_q`.
  - 1: `fill_q` with a 1-pixel white border where x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1.
  - 2: 8 vertical bars by `bar_idx`, in order white, yellow, cyan, green, magenta, red, blue, black (components 00/FF).
  - 3: 32×32 checkerboard; white when x[5]^y[5]=1, else black.
  - 4: grayscale ramp; R=G=B=x[7:0], wrapping every 256 pixels.
  - 5–7: see Configuration.
- RGB outputs are forced to 0 whenever `de_out`=0.
- Reset values:
  - All outputs 0.
  - `x_cnt`, `y_cnt`, `bar_idx`, `bar_pix` = 0.
  - `pat_q` = 4 (matches the controller's power-up pattern).
  - `fill_q` = 0.
- Reset asserted mid-frame: everything returns to its reset value at once. Generation restarts at the first `de_in` after release; `y_cnt` stays 0 until the next `vs_in` rising edge or `de_in` falling edge.

## Timing
- Pipeline is 2 stages:
  - Stage 1 registers syncs, DE, x, y, bar_idx.
  - Stage 2 registers the decoded RGB and syncs.
- Latency from `vs_in`/`hs_in`/`de_in` to the `*_out` ports is exactly 2 cycles. RGB is exactly co-timed with `de_out`.
- A `pattern_set` or colour change becomes visible from the first pixel after the next `vs_in` rising edge, never mid-frame.
- If `pattern_set` changes on the same cycle as the `vs_in` rising edge, the new value is captured.
- No backpressure; one pixel per clock.

## Configuration
- `PATTERN_GEN_GRID_EN` defined: `pat_q` 5–7 selects a grid pattern. Pixel is white when x[5:0]=0, y[5:0]=0, x=H_ACTIVE-1 or y=V_ACTIVE-1; otherwise `fill_q`.
- Macro undefined: `pat_q` 5–7 outputs black (0,0,0) with syncs unaffected. No grid logic is synthesized.

## Test plan
- Reset, then a 1280×720 frame with `pattern_set`=0 and colour {00,FF,00} latched at `vs_in` → every `de_out` pixel is 00/FF/00; `de_out` lags `de_in` by exactly 2 cycles.
- `pattern_set`=2 → pixels 0–159 are FFFFFF, pixel 160 is FFFF00, pixels 1120–1279 are 000000.
- `pattern_set`=3 → (x=31,y=0) is black, (x=32,y=0) is white, (x=32,y=32) is black.
- `pattern_set`=4 → pixel x=5 is 050505, x=256 is 000000; with `de_in` low, RGB is 0.
- `pattern_set` switched 0→2 mid-frame → current frame stays solid; the bars appear only after the next `vs_in` rising edge. Assert `rst_n` mid-line → outputs 0 immediately and `pat_q` reads 4.
- `pattern_set`=5: with the macro defined, (0,0) and (64,10) are white and (1,1) is `fill_q`; with the macro undefined, all active pixels are 000000.
